// File: rtl/bft_stream_packer.sv
// bft_stream_packer: wraps a 32-bit user AXI-stream into 49-bit BFT packets for one remote leaf/port.
// Latency: a payload accepted at edge N is on o_bft_data from N+1 until the first edge with i_bft_ready=1.
// Backpressure: TREADY drops when the remote buffer has no credit or the held packet is stalled by the BFT.
//
// Ports:
//   ap_clk, ap_rst_n              clock, asynchronous active-low reset
//   cfg_dest_leaf, cfg_dest_port  destination fields, captured per packet at accept
//   Input_1_V_T{DATA,VALID,READY} user payload stream
//   o_bft_data, i_bft_ready       packet toward the BFT and its accept strobe
//   i_bft_data                    packets returned from the BFT; only freespace updates are used
//   o_credit                      free entries left in the remote buffer (0..D)
//   o_pkt_count                   packets handed to the BFT, wraps at 2^32
//   o_credit_overflow             sticky: an update pushed the credit above D
module bft_stream_packer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
  input  logic [PAYLOAD_BITS-1:0]  Input_1_V_TDATA,
  input  logic                     Input_1_V_TVALID,
  output logic                     Input_1_V_TREADY,
  output logic [PACKET_BITS-1:0]   o_bft_data,
  input  logic                     i_bft_ready,
  input  logic [PACKET_BITS-1:0]   i_bft_data,
  output logic [NUM_ADDR_BITS:0]   o_credit,
  output logic [31:0]              o_pkt_count,
  output logic                     o_credit_overflow
);

  localparam int CW       = NUM_ADDR_BITS + 1;          // credit width, holds 0..D
  localparam int PORT_LSB = PAYLOAD_BITS + NUM_ADDR_BITS;
  localparam int PORT_MSB = PORT_LSB + NUM_PORT_BITS - 1;

  // One extra bit over the credit register so credit + update cannot wrap
  // before the saturation compare.
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(1 << NUM_ADDR_BITS);
  localparam logic [CW:0] UPD_SIZE   = (CW+1)'(FREESPACE_UPDATE_SIZE);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t                   state, state_next;
  logic                     load;
  logic                     deliver;
  logic                     accept;
  logic                     update;
  logic [NUM_ADDR_BITS-1:0] wr_addr;
  logic [CW-1:0]            credit;
  logic [CW:0]              credit_sum;
  logic                     credit_sat;
  logic [PACKET_BITS-1:0]   pkt_reg;
  logic [PACKET_BITS-1:0]   pkt_new;
  logic [31:0]              pkt_count;
  logic                     overflow;
  logic                     unused_rx_bits;

  // Only the valid bit and the port field of returned packets matter; a
  // port of 0 marks a freespace update since user ports are never 0.
  assign update = i_bft_data[PACKET_BITS-1] &&
                  (i_bft_data[PORT_MSB:PORT_LSB] == '0);
  assign unused_rx_bits = ^{i_bft_data[PACKET_BITS-2:PORT_MSB+1],
                            i_bft_data[PORT_LSB-1:0]};

  assign Input_1_V_TREADY = (credit != '0) && ((state == S_EMPTY) || i_bft_ready);
  assign accept           = Input_1_V_TVALID && Input_1_V_TREADY;
  assign deliver          = (state == S_HOLD) && i_bft_ready;

  assign pkt_new = {1'b1, cfg_dest_leaf, cfg_dest_port, wr_addr, Input_1_V_TDATA};

  // Output register state machine.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= S_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      S_EMPTY: begin
        if (accept) begin
          state_next = S_HOLD;
          load       = 1'b1;
        end
      end
      S_HOLD: begin
        if (i_bft_ready) begin
          if (accept) begin
            load = 1'b1;            // reload in the same cycle as delivery
          end else begin
            state_next = S_EMPTY;
          end
        end
      end
      default: state_next = S_EMPTY;
    endcase
  end

  // Packet register is zeroed when it empties so o_bft_data needs no mux.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      pkt_reg <= '0;
    end else if (load) begin
      pkt_reg <= pkt_new;
    end else if (deliver) begin
      pkt_reg <= '0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_addr <= '0;
    end else if (accept) begin
      wr_addr <= wr_addr + 1'b1;    // natural wrap at D
    end
  end

  // Accept only happens with credit != 0, so the subtraction never underflows.
  always_comb begin
    credit_sum = {1'b0, credit};
    if (update) begin
      credit_sum = credit_sum + UPD_SIZE;
    end
    if (accept) begin
      credit_sum = credit_sum - 1'b1;
    end
    credit_sat = (credit_sum > CREDIT_MAX);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      credit   <= CREDIT_MAX[CW-1:0];
      overflow <= 1'b0;
    end else begin
      if (credit_sat) begin
        credit   <= CREDIT_MAX[CW-1:0];
        overflow <= 1'b1;
      end else begin
        credit <= credit_sum[CW-1:0];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      pkt_count <= '0;
    end else if (deliver) begin
      pkt_count <= pkt_count + 32'd1;
    end
  end

  assign o_bft_data        = pkt_reg;
  assign o_credit          = credit;
  assign o_pkt_count       = pkt_count;
  assign o_credit_overflow = overflow;

endmodule

// File: tb/tb_bft_stream_packer.sv
module tb_bft_stream_packer;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [4:0]  cfg_dest_leaf;
  logic [3:0]  cfg_dest_port;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic [48:0] o_bft_data;
  logic        i_bft_ready;
  logic [48:0] i_bft_data;
  logic [7:0]  o_credit;
  logic [31:0] o_pkt_count;
  logic        o_credit_overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  bft_stream_packer dut (
    .ap_clk            (ap_clk),
    .ap_rst_n          (ap_rst_n),
    .cfg_dest_leaf     (cfg_dest_leaf),
    .cfg_dest_port     (cfg_dest_port),
    .Input_1_V_TDATA   (tdata),
    .Input_1_V_TVALID  (tvalid),
    .Input_1_V_TREADY  (tready),
    .o_bft_data        (o_bft_data),
    .i_bft_ready       (i_bft_ready),
    .i_bft_data        (i_bft_data),
    .o_credit          (o_credit),
    .o_pkt_count       (o_pkt_count),
    .o_credit_overflow (o_credit_overflow)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic [48:0] mkpkt(input logic [4:0] leaf, input logic [3:0] port,
                                        input logic [6:0] addr, input logic [31:0] data);
    return {1'b1, leaf, port, addr, data};
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0; cfg_dest_leaf = 5'd5; cfg_dest_port = 4'd2;
    tdata = '0; tvalid = 1'b0; i_bft_ready = 1'b1; i_bft_data = '0;
    #12;
    if (o_bft_data !== 49'd0) begin n_fail++; $display("FAIL rst_data got %h want 0", o_bft_data); end
    n_cmp++;
    ap_rst_n = 1'b1;
    tick();
    if (o_bft_data !== 49'd0) begin n_fail++; $display("FAIL rst_data2 got %h want 0", o_bft_data); end
    n_cmp++;
    if (o_credit !== 8'd128) begin n_fail++; $display("FAIL rst_credit got %0d want 128", o_credit); end
    n_cmp++;
    if (tready !== 1'b1) begin n_fail++; $display("FAIL rst_tready got %b want 1", tready); end
    n_cmp++;
    if (o_pkt_count !== 32'd0) begin n_fail++; $display("FAIL rst_pktcnt got %0d want 0", o_pkt_count); end
    n_cmp++;
    if (o_credit_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b want 0", o_credit_overflow); end
    n_cmp++;
  endtask

  task automatic test_streaming();
    for (int k = 0; k < 130; k++) begin
      tdata = 32'(k); tvalid = 1'b1;
      #1;
      if (tready !== (k < 128)) begin
        n_fail++; $display("FAIL stream_tready k=%0d got %b want %b", k, tready, (k < 128));
      end
      n_cmp++;
      tick();
      if (k < 128) begin
        if (o_bft_data !== mkpkt(5'd5, 4'd2, 7'(k), 32'(k))) begin
          n_fail++; $display("FAIL stream_pkt k=%0d got %h want %h", k, o_bft_data, mkpkt(5'd5, 4'd2, 7'(k), 32'(k)));
        end
        n_cmp++;
        if (o_credit !== 8'(127 - k)) begin
          n_fail++; $display("FAIL stream_credit k=%0d got %0d want %0d", k, o_credit, 127 - k);
        end
        n_cmp++;
        if (o_pkt_count !== 32'(k)) begin
          n_fail++; $display("FAIL stream_pktcnt k=%0d got %0d want %0d", k, o_pkt_count, k);
        end
        n_cmp++;
      end
    end
    if (o_credit !== 8'd0) begin n_fail++; $display("FAIL exhaust_credit got %0d want 0", o_credit); end
    n_cmp++;
    if (o_pkt_count !== 32'd128) begin n_fail++; $display("FAIL exhaust_pktcnt got %0d want 128", o_pkt_count); end
    n_cmp++;
    if (o_bft_data !== 49'd0) begin n_fail++; $display("FAIL exhaust_data got %h want 0", o_bft_data); end
    n_cmp++;
  endtask

  task automatic test_credit_return();
    logic [48:0] p;
    tdata = 32'd128; tvalid = 1'b1;
    i_bft_data = mkpkt(5'd9, 4'd3, 7'd0, 32'd0);   // non-zero port: ignored
    tick();
    if (o_credit !== 8'd0) begin n_fail++; $display("FAIL ignore_port got %0d want 0", o_credit); end
    n_cmp++;
    p = mkpkt(5'd9, 4'd0, 7'd0, 32'd0);
    p[48] = 1'b0;                                    // invalid: ignored
    i_bft_data = p;
    tick();
    if (o_credit !== 8'd0) begin n_fail++; $display("FAIL ignore_invalid got %0d want 0", o_credit); end
    n_cmp++;
    i_bft_data = mkpkt(5'd9, 4'd0, 7'd5, 32'h0000_FEED);
    tick();
    i_bft_data = '0;
    if (o_credit !== 8'd64) begin n_fail++; $display("FAIL update_credit got %0d want 64", o_credit); end
    n_cmp++;
    #1;
    if (tready !== 1'b1) begin n_fail++; $display("FAIL update_tready got %b want 1", tready); end
    n_cmp++;
    tick();
    if (o_bft_data !== mkpkt(5'd5, 4'd2, 7'd0, 32'd128)) begin
      n_fail++; $display("FAIL wrap_pkt got %h want %h", o_bft_data, mkpkt(5'd5, 4'd2, 7'd0, 32'd128));
    end
    n_cmp++;
    if (o_credit !== 8'd63) begin n_fail++; $display("FAIL wrap_credit got %0d want 63", o_credit); end
    n_cmp++;
  endtask

  task automatic test_backpressure();
    i_bft_ready = 1'b0; tdata = 32'd129; tvalid = 1'b1;
    #1;
    if (tready !== 1'b0) begin n_fail++; $display("FAIL bp_tready got %b want 0", tready); end
    n_cmp++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_bft_data !== mkpkt(5'd5, 4'd2, 7'd0, 32'd128)) begin
        n_fail++; $display("FAIL bp_hold i=%0d got %h", i, o_bft_data);
      end
      n_cmp++;
      if (o_pkt_count !== 32'd128) begin n_fail++; $display("FAIL bp_pktcnt i=%0d got %0d want 128", i, o_pkt_count); end
      n_cmp++;
      if (tready !== 1'b0) begin n_fail++; $display("FAIL bp_tready_hold i=%0d got %b want 0", i, tready); end
      n_cmp++;
    end
    i_bft_ready = 1'b1;
    #1;
    if (tready !== 1'b1) begin n_fail++; $display("FAIL bp_release_tready got %b want 1", tready); end
    n_cmp++;
    tick();
    if (o_bft_data !== mkpkt(5'd5, 4'd2, 7'd1, 32'd129)) begin
      n_fail++; $display("FAIL bp_reload got %h want %h", o_bft_data, mkpkt(5'd5, 4'd2, 7'd1, 32'd129));
    end
    n_cmp++;
    if (o_pkt_count !== 32'd129) begin n_fail++; $display("FAIL bp_deliver got %0d want 129", o_pkt_count); end
    n_cmp++;
    if (o_credit !== 8'd62) begin n_fail++; $display("FAIL bp_credit got %0d want 62", o_credit); end
    n_cmp++;
    tvalid = 1'b0;
    tick();
    if (o_pkt_count !== 32'd130) begin n_fail++; $display("FAIL bp_drain_cnt got %0d want 130", o_pkt_count); end
    n_cmp++;
    if (o_bft_data !== 49'd0) begin n_fail++; $display("FAIL bp_drain_data got %h want 0", o_bft_data); end
    n_cmp++;
  endtask

  task automatic test_simultaneous();
    tvalid = 1'b1;
    for (int i = 0; i < 52; i++) begin
      tdata = 32'(1000 + i);
      tick();
    end
    if (o_credit !== 8'd10) begin n_fail++; $display("FAIL sim_pre_credit got %0d want 10", o_credit); end
    n_cmp++;
    if (o_bft_data !== mkpkt(5'd5, 4'd2, 7'd53, 32'd1051)) begin
      n_fail++; $display("FAIL sim_pre_pkt got %h want %h", o_bft_data, mkpkt(5'd5, 4'd2, 7'd53, 32'd1051));
    end
    n_cmp++;
    tdata = 32'd2000;
    i_bft_data = mkpkt(5'd0, 4'd0, 7'd0, 32'd0);
    tick();
    i_bft_data = '0; tvalid = 1'b0;
    if (o_credit !== 8'd73) begin n_fail++; $display("FAIL sim_credit got %0d want 73", o_credit); end
    n_cmp++;
    if (o_credit_overflow !== 1'b0) begin n_fail++; $display("FAIL sim_ovf got %b want 0", o_credit_overflow); end
    n_cmp++;
    if (o_bft_data !== mkpkt(5'd5, 4'd2, 7'd54, 32'd2000)) begin
      n_fail++; $display("FAIL sim_pkt got %h want %h", o_bft_data, mkpkt(5'd5, 4'd2, 7'd54, 32'd2000));
    end
    n_cmp++;
    tick();
  endtask

  task automatic test_overflow();
    ap_rst_n = 1'b0;
    #3;
    ap_rst_n = 1'b1;
    tick();
    if (o_credit !== 8'd128) begin n_fail++; $display("FAIL ovf_pre_credit got %0d want 128", o_credit); end
    n_cmp++;
    i_bft_data = mkpkt(5'd3, 4'd0, 7'd0, 32'd0);
    tick();
    i_bft_data = '0;
    if (o_credit !== 8'd128) begin n_fail++; $display("FAIL ovf_credit got %0d want 128", o_credit); end
    n_cmp++;
    if (o_credit_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", o_credit_overflow); end
    n_cmp++;
    tdata = 32'd7; tvalid = 1'b1;
    tick();
    tvalid = 1'b0;
    if (o_credit !== 8'd127) begin n_fail++; $display("FAIL ovf_after_credit got %0d want 127", o_credit); end
    n_cmp++;
    tick();
    tick();
    if (o_credit_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", o_credit_overflow); end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    // wr_addr is 1 here; 36 more packets bring it to 37.
    tvalid = 1'b1;
    for (int i = 0; i < 36; i++) begin
      tdata = 32'(i);
      tick();
    end
    tvalid = 1'b0;
    tick();
    i_bft_ready = 1'b0; tvalid = 1'b1; tdata = 32'h0000_ABCD;
    tick();
    tvalid = 1'b0;
    if (o_bft_data !== mkpkt(5'd5, 4'd2, 7'd37, 32'h0000_ABCD)) begin
      n_fail++; $display("FAIL mid_hold got %h want %h", o_bft_data, mkpkt(5'd5, 4'd2, 7'd37, 32'h0000_ABCD));
    end
    n_cmp++;
    cfg_dest_leaf = 5'd7;
    tick();
    if (o_bft_data !== mkpkt(5'd5, 4'd2, 7'd37, 32'h0000_ABCD)) begin
      n_fail++; $display("FAIL cfg_change got %h", o_bft_data);
    end
    n_cmp++;
    #2;
    ap_rst_n = 1'b0;
    #1;
    if (o_bft_data !== 49'd0) begin n_fail++; $display("FAIL mid_rst_data got %h want 0", o_bft_data); end
    n_cmp++;
    if (o_credit !== 8'd128) begin n_fail++; $display("FAIL mid_rst_credit got %0d want 128", o_credit); end
    n_cmp++;
    if (o_credit_overflow !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ovf got %b want 0", o_credit_overflow); end
    n_cmp++;
    if (o_pkt_count !== 32'd0) begin n_fail++; $display("FAIL mid_rst_pktcnt got %0d want 0", o_pkt_count); end
    n_cmp++;
    #2;
    ap_rst_n = 1'b1;
    tick();
    i_bft_ready = 1'b1; tvalid = 1'b1; tdata = 32'h55;
    tick();
    tvalid = 1'b0;
    if (o_bft_data !== mkpkt(5'd7, 4'd2, 7'd0, 32'h55)) begin
      n_fail++; $display("FAIL mid_after_pkt got %h want %h", o_bft_data, mkpkt(5'd7, 4'd2, 7'd0, 32'h55));
    end
    n_cmp++;
    if (o_credit !== 8'd127) begin n_fail++; $display("FAIL mid_after_credit got %0d want 127", o_credit); end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_credit_return();
    test_backpressure();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
